// File: rtl/mult84_pkg.sv
// Shared widths, state encoding and step count for the 8x4 shift-add multiplier.
// Also holds the invalid-divide-tuple predicate used when a result is committed.
package mult84_pkg;

    localparam int QUO_W  = 8;
    localparam int DEN_W  = 4;
    localparam int PROD_W = 12;
    localparam int STEPS  = 4;
    localparam int CNT_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A remainder must be strictly below its denominator; d == 0 is always invalid.
    function automatic logic rem_invalid(input logic [DEN_W-1:0] den,
                                         input logic [DEN_W-1:0] rem);
        return (den == '0) || (rem >= den);
    endfunction

endpackage

// File: rtl/mult84_seq.sv
// Sequential shift-add multiplier rebuilding numerator = quotient*denominator + remainder,
// one multiplier bit per BUSY cycle, with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid; captures operands and seeds acc with remainder
// BUSY  | four shift-add steps over denominator bits 0..3; in_valid ignored
// DONE  | out_valid=1 with registered product/rem_err; retires on out_ready
module mult84_seq
    import mult84_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [QUO_W-1:0]  quotient,
    input  logic [DEN_W-1:0]  denominator,
    input  logic [DEN_W-1:0]  remainder,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              rem_err
);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PROD_W-1:0] r_acc;
    logic [QUO_W-1:0]  r_quo;
    logic [DEN_W-1:0]  r_den;
    logic [DEN_W-1:0]  r_rem;
    logic [PROD_W-1:0] r_product;
    logic              r_rem_err;

    logic [PROD_W-1:0] w_addend;
    logic [PROD_W-1:0] w_acc_next;
    logic              w_last_step;

    // Partial product for the current multiplier bit; the sum never exceeds 3840, so 12 bits suffice.
    assign w_addend    = r_den[r_cnt] ? (PROD_W'(r_quo) << r_cnt) : '0;
    assign w_acc_next  = r_acc + w_addend;
    assign w_last_step = (r_cnt == CNT_W'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_quo     <= '0;
            r_den     <= '0;
            r_rem     <= '0;
            r_product <= '0;
            r_rem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_quo   <= quotient;
                        r_den   <= denominator;
                        r_rem   <= remainder;
                        r_acc   <= PROD_W'(remainder);
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_step) begin
                        // Outputs change only here, so they hold through DONE and the following IDLE.
                        r_product <= w_acc_next;
                        r_rem_err <= rem_invalid(r_den, r_rem);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign product   = r_product;
    assign rem_err   = r_rem_err;

endmodule

// File: tb/tb_mult84_seq.sv
// Scoreboard bench for mult84_seq: stimulus pushes expected {rem_err, product},
// a negedge monitor pops and compares on every retired result.
module tb_mult84_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  quotient = '0;
    logic [3:0]  denominator = '0;
    logic [3:0]  remainder = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] product;
    logic        rem_err;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_retire = -1;
    bit sweep_mode  = 1'b0;
    logic [12:0] exp_q[$];

    mult84_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .quotient    (quotient),
        .denominator (denominator),
        .remainder   (remainder),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .rem_err     (rem_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d required=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every handshake-completing cycle retires exactly one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got product=%0d rem_err=%0d required=no result", product, rem_err);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("product", 32'(product), 32'(e[11:0]));
                check("rem_err", 32'(rem_err), 32'(e[12]));
                if (sweep_mode && last_retire >= 0)
                    check("spacing", 32'(cyc - last_retire), 32'd6);
                last_retire = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_ready_timeout: got in_ready=0 required=1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic send(input logic [7:0] q, input logic [3:0] d, input logic [3:0] r,
                        input logic [11:0] ep, input logic ee, input bit push);
        wait_ready();
        quotient    = q;
        denominator = d;
        remainder   = r;
        in_valid    = 1'b1;
        if (push) exp_q.push_back({ee, ep});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        logic [7:0] qlist [7];
        qlist = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h5A, 8'hA5, 8'h37};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_rem_err", 32'(rem_err), 32'd0);

        // 28*7+4 = 200; out_valid appears after the 4th edge following acceptance
        out_ready = 1'b1;
        send(8'd28, 4'd7, 4'd4, 12'd200, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
            if (k == 1) check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        check("latency_edges", 32'(k), 32'd4);
        tick();

        send(8'd255, 4'd15, 4'd15, 12'd3840, 1'b1, 1'b1);
        send(8'hAB, 4'd0, 4'd3, 12'd3, 1'b1, 1'b1);
        drain();

        // Backpressure: 0x12*5+2 = 92, rem 2 < 5 so valid tuple
        out_ready = 1'b0;
        send(8'h12, 4'd5, 4'd2, 12'd92, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            quotient    = 8'hFF;
            denominator = 4'hF;
            remainder   = 4'h0;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(product), 32'd92);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_retired_in_ready", 32'(in_ready), 32'd1);
        check("bp_retired_out_valid", 32'(out_valid), 32'd0);
        check("bp_hold_product", 32'(product), 32'd92);
        drain();

        // Abort on the 2nd BUSY cycle; the 0x33 op must never be presented
        send(8'h33, 4'd9, 4'd1, 12'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_product", 32'(product), 32'd0);
        send(8'd1, 4'd1, 4'd0, 12'd1, 1'b0, 1'b1);
        drain();

        // Back-to-back sweep with in_valid held high; also checks 6-cycle spacing
        sweep_mode  = 1'b1;
        last_retire = -1;
        in_valid    = 1'b1;
        foreach (qlist[qi]) begin
            for (int d = 0; d < 16; d++) begin
                for (int r = 0; r < 16; r++) begin
                    wait_ready();
                    quotient    = qlist[qi];
                    denominator = 4'(d);
                    remainder   = 4'(r);
                    exp_q.push_back({(d == 0) || (r >= d), 12'(int'(qlist[qi]) * d + r)});
                    tick();
                end
            end
        end
        in_valid = 1'b0;
        drain();
        sweep_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
